uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares the single UART transmitter between N requesters. It drives the UART's `transmit`/`data_tx` inputs and paces bytes with an internal hold-off timer, because the UART exposes no busy/ready output. A packet lock keeps ownership across multi-byte messages. A lock timeout stops a stalled owner from starving the other requesters.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BYTE_CYCLES`, 6600: clocks reserved per byte. Must be ≥ 15 × 435 = 6525, the UART frame length in clocks.
- `LOCK_CYCLES`, 100000: idle clocks a locked owner may hold the UART before the lock is forcibly released.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester byte request (level).
- `data`  in  8·N_REQ  byte for requester i at bits [8i+7:8i].
- `last`  in  N_REQ  byte is the final byte of its packet.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: byte accepted.
- `transmit`  out  1  one-cycle pulse to the UART.
- `data_tx`  out  8  byte to the UART, valid while `transmit`=1 and held afterwards.
- `busy`  out  1  high in WAIT.
- `grant_id`  out  clog2(N_REQ)  last granted requester.
- `locked`  out  1  packet lock held.
- `lock_err`  out  1  one-cycle pulse on lock timeout.

## Operation
- States: IDLE and WAIT.
- Reset values: state=IDLE; `ack`=0; `transmit`=0; `data_tx`=0; `busy`=0; `grant_id`=N_REQ-1; `locked`=0; `lock_err`=0. Both counters are 0.

IDLE:
- Eligible set: `req` when unlocked; `req & (1<<grant_id)` when locked.
- If the eligible set is non-empty, the winner is the first eligible index starting at `grant_id`+1, wrapping modulo N_REQ.
- On the same edge:
  - `data_tx` ← winner's byte.
  - `transmit`=1 and `ack[winner]`=1.
  - `grant_id` ← winner.
  - `locked` ← ~`last[winner]`.
  - Timer loaded with BYTE_CYCLES-1; next state is WAIT.
- If locked and the owner's `req` is low, the lock counter increments.
  - When it reaches LOCK_CYCLES: `locked` ← 0, `lock_err` pulses, counter clears.
  - The counter clears on every grant and whenever the block is unlocked.

WAIT:
- Timer decrements every cycle. `req`, `data` and `last` are ignored.
- At timer=0 the next state is IDLE.

Requester rules:
- `req`, `data` and `last` stay stable from assertion until `ack`.
- In the cycle after `ack`, the requester drops `req` or presents its next byte.
- The arbiter never withdraws a request and never drops a byte.

Other rules:
- The lock changes eligibility only. It never reorders bytes within a packet.
- A single-byte packet is `last`=1 on its first byte; `locked` stays 0.
- Requests that arrive during WAIT are queued by level only; there is no FIFO.
- Reset mid-WAIT returns to IDLE immediately and drives `transmit` low. A frame already in progress in the UART completes on the line; the UART has its own reset.

## Timing
- `req` high in IDLE at edge k gives `transmit`=`ack`=1 during cycle k+1, exactly one cycle wide.
- Back-to-back grants: consecutive `transmit` pulses are exactly BYTE_CYCLES+1 clocks apart. That is 1 issue cycle plus BYTE_CYCLES in WAIT, with arbitration on the first IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous `req` from all requesters after reset are served in the order 0,1,2,3,0,…
- Lock timeout happens exactly LOCK_CYCLES IDLE clocks after the owner's `req` went low. Arbitration among the others starts on the cycle after the `lock_err` pulse.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_CLKS_PER_BIT`=435 and `UART_FRAME_BITS`=15.
  - Derived `UART_FRAME_CLKS`, used for the default of BYTE_CYCLES.
  - The `arb_state_t` enum {IDLE, WAIT}.
- One sub-module `uart_rr_pick`: combinational round-robin picker.
  - Inputs: eligible mask and last-grant index.
  - Outputs: `valid` and winner index.

## Test plan
Run with BYTE_CYCLES=16 and LOCK_CYCLES=8.
1. Single request: `req`=0001, `data[7:0]`=0x41, `last`=1.
   - One `transmit` with `data_tx`=0x41 one cycle after `req`; `ack`=0001 in the same cycle.
   - `busy` high for 16 cycles; `locked` stays 0.
2. Round-robin: all four `req` held with `last`=1.
   - Grants in the order 0,1,2,3,0; `transmit` pulses 17 clocks apart; `grant_id` follows.
3. Packet lock: req0 sends 0x10 (`last`=0), 0x11 (`last`=0), 0x12 (`last`=1) while req2 is held.
   - Byte order on `data_tx` is 0x10, 0x11, 0x12, then req2's byte; `locked` is 1 between 0x10 and 0x12.
4. Lock timeout: req1 sends 0x55 with `last`=0, then drops `req`; req3 is held.
   - `lock_err` pulses 8 IDLE cycles after the byte completes; `locked`=0; req3 is granted on the next cycle.
5. Reset mid-WAIT: assert `rst` 5 cycles after a `transmit`.
   - All outputs return to reset values asynchronously; the first grant after reset goes to requester 0.
6. Request during WAIT: req1 rises at timer=3.
   - Granted exactly at the first IDLE cycle; no early `transmit`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART timing constants and the arbiter state type.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 435;
    localparam int unsigned UART_FRAME_BITS   = 15;
    localparam int unsigned UART_FRAME_CLKS   = UART_CLKS_PER_BIT * UART_FRAME_BITS;

    typedef enum logic {IDLE, WAIT} arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_id, wrapping.
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         eligible,
    input  logic [$clog2(N_REQ)-1:0] last_id,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] winner
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            idx = (int'(last_id) + off) % int'(N_REQ);
            if (!valid && eligible[idx[ID_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter, with byte pacing and packet lock.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    // Frame length plus a small guard so a new frame never overlaps the stop bits.
    parameter int unsigned BYTE_CYCLES = UART_FRAME_CLKS + 75,
    parameter int unsigned LOCK_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    input  logic [N_REQ-1:0]         last,
    output logic [N_REQ-1:0]         ack,
    output logic                     transmit,
    output logic [7:0]               data_tx,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     locked,
    output logic                     lock_err
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(BYTE_CYCLES);
    localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

    arb_state_t       state;
    logic [TMR_W-1:0] timer;
    logic [LCK_W-1:0] lock_cnt;
    logic [N_REQ-1:0] owner_mask;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] win_onehot;
    logic             pick_valid;
    logic [ID_W-1:0]  winner;
    logic [7:0]       bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign bytes[g] = data[8*g +: 8];
    end

    always_comb begin
        owner_mask           = '0;
        owner_mask[grant_id] = 1'b1;
        eligible             = locked ? (req & owner_mask) : req;
        win_onehot           = '0;
        win_onehot[winner]   = 1'b1;
    end

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .eligible (eligible),
        .last_id  (grant_id),
        .valid    (pick_valid),
        .winner   (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            lock_cnt <= '0;
            ack      <= '0;
            transmit <= 1'b0;
            data_tx  <= 8'h00;
            busy     <= 1'b0;
            grant_id <= ID_W'(N_REQ - 1);
            locked   <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            ack      <= '0;
            transmit <= 1'b0;
            lock_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= WAIT;
                        ack      <= win_onehot;
                        transmit <= 1'b1;
                        data_tx  <= bytes[winner];
                        busy     <= 1'b1;
                        grant_id <= winner;
                        locked   <= ~last[winner];
                        timer    <= TMR_W'(BYTE_CYCLES - 1);
                        lock_cnt <= '0;
                    end else if (locked) begin
                        // No pick while locked means the owner's req is low.
                        if (lock_cnt == LCK_W'(LOCK_CYCLES - 1)) begin
                            locked   <= 1'b0;
                            lock_err <= 1'b1;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end else begin
                        lock_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
